// File: rtl/arbitro_rr_4x1.sv
// Four-input round-robin burst arbiter that pops input FIFOs into one downstream FIFO.
// Optional ARB_STRICT_PRIO_EN gives queue 0 absolute priority; the source index port is
// src_class because "class" is a reserved word in SystemVerilog.
module arbitro_rr_4x1 #(
  parameter int BURST_LEN = 4
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [3:0] FIFO_empty,
  input  logic       Almost_full,
  output logic [3:0] Pop,
  output logic       Push,
  output logic [1:0] src_class
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam logic [2:0] LAST_CNT = 3'(BURST_LEN - 1);

  state_t     state_r, state_nx_s;
  logic [1:0] cur_r, cur_nx_s;
  logic [1:0] ptr_r, ptr_nx_s;
  logic [2:0] cnt_r, cnt_nx_s;
  logic       push_r;
  logic [1:0] class_r;
  logic [1:0] rr_sel_s;
  logic [1:0] sel_s;
  logic [1:0] cand_s;
  logic       pop_en_s;

  // Round-robin pick: scan downwards so the lowest offset from ptr wins.
  always_comb begin
    rr_sel_s = ptr_r;
    cand_s   = ptr_r;
    for (int i = 3; i >= 0; i--) begin
      cand_s   = ptr_r + 2'(i);
      rr_sel_s = FIFO_empty[cand_s] ? rr_sel_s : cand_s;
    end
`ifdef ARB_STRICT_PRIO_EN
    if (!FIFO_empty[0]) begin
      sel_s = 2'd0;
    end else begin
      sel_s = rr_sel_s;
    end
`else
    sel_s = rr_sel_s;
`endif
  end

  // Pop strobe and next-state logic of the arbitration FSM.
  always_comb begin
    state_nx_s = state_r;
    cur_nx_s   = cur_r;
    ptr_nx_s   = ptr_r;
    cnt_nx_s   = cnt_r;
    pop_en_s   = 1'b0;
    Pop        = 4'b0000;
    case (state_r)
      IDLE: begin
        if ((~&FIFO_empty) && !Almost_full) begin
          cur_nx_s   = sel_s;
          cnt_nx_s   = 3'd0;
          state_nx_s = SERVE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SERVE: begin
        // An empty granted queue ends the burst even while downstream is stalled.
        if (FIFO_empty[cur_r]) begin
          state_nx_s = IDLE;
          ptr_nx_s   = cur_r + 2'd1;
        end else if (Almost_full) begin
          state_nx_s = SERVE;
        end else begin
          pop_en_s = 1'b1;
          Pop      = 4'b0001 << cur_r;
          cnt_nx_s = cnt_r + 3'd1;
          if (cnt_r == LAST_CNT) begin
            state_nx_s = IDLE;
            ptr_nx_s   = cur_r + 2'd1;
          end else begin
            state_nx_s = SERVE;
          end
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // FSM and arbitration registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_r <= IDLE;
      cur_r   <= 2'd0;
      ptr_r   <= 2'd0;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_nx_s;
      cur_r   <= cur_nx_s;
      ptr_r   <= ptr_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Downstream write strobe and source tag, one cycle behind Pop.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      push_r  <= 1'b0;
      class_r <= 2'd0;
    end else begin
      push_r  <= pop_en_s;
      class_r <= pop_en_s ? cur_r : class_r;
    end
  end

  assign Push      = push_r;
  assign src_class = class_r;

endmodule
